// File: rtl/core_lsu_pkg.sv
// Shared load/store unit definitions: access encodings, size codes and FSM states.
package core_lsu_pkg;

  // Load size/sign encodings carried on read_type
  localparam logic [2:0] RT_LB  = 3'd0;
  localparam logic [2:0] RT_LH  = 3'd1;
  localparam logic [2:0] RT_LW  = 3'd2;
  localparam logic [2:0] RT_LD  = 3'd3;
  localparam logic [2:0] RT_LBU = 3'd4;
  localparam logic [2:0] RT_LHU = 3'd5;
  localparam logic [2:0] RT_LWU = 3'd6;

  // Store size encodings carried on write_type (numerically equal to the size code)
  localparam logic [1:0] WT_SB = 2'd0;
  localparam logic [1:0] WT_SH = 2'd1;
  localparam logic [1:0] WT_SW = 2'd2;
  localparam logic [1:0] WT_SD = 2'd3;

  // Access size as log2(bytes)
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Load size from read_type; the unused code 7 behaves as a doubleword load
  function automatic logic [1:0] read_size(input logic [2:0] rt);
    logic [1:0] sz;
    case (rt)
      RT_LB, RT_LBU: sz = SZ_B;
      RT_LH, RT_LHU: sz = SZ_H;
      RT_LW, RT_LWU: sz = SZ_W;
      default:       sz = SZ_D;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational datapath of the LSU: alignment check, store lane/strobe
// generation and load byte extraction with sign/zero extension.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              is_read_i,
  input  logic [2:0]        read_type_i,
  input  logic [1:0]        write_type_i,
  input  logic [2:0]        offset_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              misaligned_o,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [XLEN-1:0]   wdata_o,
  input  logic [2:0]        ld_type_i,
  input  logic [2:0]        ld_offset_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  logic [1:0]        size;
  logic [STRB_W-1:0] strb_base;
  logic [XLEN-1:0]   ld_shift;

  // Alignment check against the size of the access actually performed (read wins)
  always_comb begin
    size = is_read_i ? read_size(read_type_i) : write_type_i;
    case (size)
      SZ_B:    misaligned_o = 1'b0;
      SZ_H:    misaligned_o = offset_i[0];
      SZ_W:    misaligned_o = |offset_i[1:0];
      default: misaligned_o = |offset_i;
    endcase
  end

  // Store byte enables and lane-shifted store data
  always_comb begin
    case (write_type_i)
      WT_SB:   strb_base = STRB_W'(8'h01);
      WT_SH:   strb_base = STRB_W'(8'h03);
      WT_SW:   strb_base = STRB_W'(8'h0F);
      default: strb_base = {STRB_W{1'b1}};
    endcase
    wstrb_o = strb_base << offset_i;
    wdata_o = wdata_i << {offset_i, 3'b000};
  end

  // Pull the addressed bytes down to bit 0 and extend per load type
  always_comb begin
    ld_shift = rdata_i >> {ld_offset_i, 3'b000};
    case (ld_type_i)
      RT_LB:   rdata_o = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
      RT_LH:   rdata_o = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      RT_LW:   rdata_o = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      RT_LBU:  rdata_o = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
      RT_LHU:  rdata_o = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
      RT_LWU:  rdata_o = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
      default: rdata_o = ld_shift;
    endcase
  end

endmodule

// File: rtl/core_lsu_ctrl.sv
// MEM-stage load/store sequencer: turns mem_read/mem_write into a
// req/gnt/rvalid transaction and stalls the pipeline until it completes.
//
// state | meaning
// IDLE  | no access in flight; a legal op latches its request fields
// REQ   | dmem_req_o high, fields held until dmem_gnt_i
// WAIT  | load granted, waiting for dmem_rvalid_i
// DONE  | access complete, stall released, rdata_valid_o for loads
module core_lsu_ctrl
  import core_lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        read_type_i,
  input  logic [1:0]        write_type_i,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [STRB_W-1:0] dmem_wstrb_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic [XLEN-1:0]   rdata_o,
  output logic              rdata_valid_o,
  output logic              stall_o,
  output logic              misalign_o
);

  lsu_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic [2:0]        ld_type_q, ld_type_d;
  logic [2:0]        ld_off_q, ld_off_d;

  logic              op;
  logic              misaligned;
  logic              legal;
  logic [STRB_W-1:0] st_strb;
  logic [XLEN-1:0]   st_wdata;
  logic [XLEN-1:0]   ld_data;

  // Store path uses the live EX/MEM fields; load extraction uses the latched ones
  core_lsu_align #(
    .XLEN   (XLEN),
    .STRB_W (STRB_W)
  ) u_align (
    .is_read_i    (mem_read_i),
    .read_type_i  (read_type_i),
    .write_type_i (write_type_i),
    .offset_i     (addr_i[2:0]),
    .wdata_i      (wdata_i),
    .misaligned_o (misaligned),
    .wstrb_o      (st_strb),
    .wdata_o      (st_wdata),
    .ld_type_i    (ld_type_q),
    .ld_offset_i  (ld_off_q),
    .rdata_i      (dmem_rdata_i),
    .rdata_o      (ld_data)
  );

  assign op    = mem_read_i | mem_write_i;
  assign legal = op & ~misaligned;

  assign misalign_o    = op & misaligned;
  assign stall_o       = legal & (state_q != LSU_DONE);
  assign dmem_req_o    = req_q;
  assign dmem_we_o     = we_q;
  assign dmem_addr_o   = addr_q;
  assign dmem_wstrb_o  = wstrb_q;
  assign dmem_wdata_o  = wdata_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;

  // Next-state and registered-output logic of the access sequencer
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    ld_type_d = ld_type_q;
    ld_off_d  = ld_off_q;
    case (state_q)
      LSU_IDLE: begin
        if (legal) begin
          state_d   = LSU_REQ;
          req_d     = 1'b1;
          we_d      = ~mem_read_i;
          addr_d    = {addr_i[XLEN-1:3], 3'b000};
          // strobes and data only describe writes; loads fetch the whole doubleword
          wstrb_d   = mem_read_i ? '0 : st_strb;
          wdata_d   = mem_read_i ? '0 : st_wdata;
          ld_type_d = read_type_i;
          ld_off_d  = addr_i[2:0];
        end
      end
      LSU_REQ: begin
        if (dmem_gnt_i) begin
          req_d   = 1'b0;
          state_d = we_q ? LSU_DONE : LSU_WAIT;
        end
      end
      LSU_WAIT: begin
        if (dmem_rvalid_i) begin
          rdata_d  = ld_data;
          rvalid_d = 1'b1;
          state_d  = LSU_DONE;
        end
      end
      default: begin
        rvalid_d = 1'b0;
        state_d  = LSU_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LSU_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      ld_type_q <= '0;
      ld_off_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      ld_type_q <= ld_type_d;
      ld_off_q  <= ld_off_d;
    end
  end

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// Directed bench for core_lsu_ctrl with hand-computed expected values.
module tb_core_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [2:0]  read_type_i;
  logic [1:0]  write_type_i;
  logic [63:0] addr_i;
  logic [63:0] wdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [7:0]  dmem_wstrb_o;
  logic [63:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;
  logic [63:0] rdata_o;
  logic        rdata_valid_o;
  logic        stall_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  core_lsu_ctrl #(.XLEN(64), .STRB_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .read_type_i   (read_type_i),
    .write_type_i  (write_type_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_wstrb_o  (dmem_wstrb_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .stall_o       (stall_o),
    .misalign_o    (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled shortly after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // load with gnt in first REQ cycle and rvalid two cycles after gnt
  task automatic run_load(input string tag, input logic [2:0] rt, input logic [63:0] a,
                          input logic [63:0] raw, input logic [63:0] exp);
    mem_read_i  = 1'b1;
    read_type_i = rt;
    addr_i      = a;
    dmem_gnt_i  = 1'b0;
    #1;
    chk({tag, "_stall_idle"}, stall_o, 1'b1);
    step();
    chk({tag, "_req"}, dmem_req_o, 1'b1);
    chk({tag, "_we"}, dmem_we_o, 1'b0);
    chk({tag, "_addr"}, dmem_addr_o, {a[63:3], 3'b000});
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk({tag, "_req_wait"}, dmem_req_o, 1'b0);
    chk({tag, "_stall_wait"}, stall_o, 1'b1);
    step();
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = raw;
    step();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = 64'h0;
    chk({tag, "_rdata"}, rdata_o, exp);
    chk({tag, "_rvalid_done"}, rdata_valid_o, 1'b1);
    chk({tag, "_stall_done"}, stall_o, 1'b0);
    mem_read_i = 1'b0;
    step();
    chk({tag, "_rvalid_idle"}, rdata_valid_o, 1'b0);
    chk({tag, "_rdata_hold"}, rdata_o, exp);
  endtask

  initial begin
    rst = 1'b1;
    mem_read_i = 1'b0;
    mem_write_i = 1'b0;
    read_type_i = 3'd0;
    write_type_i = 2'd0;
    addr_i = 64'h0;
    wdata_i = 64'h0;
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 64'h0;
    repeat (2) step();
    chk("rst_req", dmem_req_o, 1'b0);
    chk("rst_we", dmem_we_o, 1'b0);
    chk("rst_addr", dmem_addr_o, 64'h0);
    chk("rst_wstrb", dmem_wstrb_o, 8'h00);
    chk("rst_wdata", dmem_wdata_o, 64'h0);
    chk("rst_rdata", rdata_o, 64'h0);
    chk("rst_rvalid", rdata_valid_o, 1'b0);
    chk("rst_stall", stall_o, 1'b0);
    rst = 1'b0;

    // SD at 0x1000, gnt on first REQ cycle
    mem_write_i = 1'b1;
    write_type_i = 2'd3;
    addr_i = 64'h1000;
    wdata_i = 64'h1122334455667788;
    dmem_gnt_i = 1'b1;
    #1;
    chk("sd_stall_idle", stall_o, 1'b1);
    chk("sd_req_idle", dmem_req_o, 1'b0);
    step();
    chk("sd_req", dmem_req_o, 1'b1);
    chk("sd_we", dmem_we_o, 1'b1);
    chk("sd_addr", dmem_addr_o, 64'h1000);
    chk("sd_wstrb", dmem_wstrb_o, 8'hFF);
    chk("sd_wdata", dmem_wdata_o, 64'h1122334455667788);
    chk("sd_stall_req", stall_o, 1'b1);
    step();
    chk("sd_req_done", dmem_req_o, 1'b0);
    chk("sd_stall_done", stall_o, 1'b0);
    chk("sd_rvalid_done", rdata_valid_o, 1'b0);
    mem_write_i = 1'b0;
    dmem_gnt_i = 1'b0;
    step();
    chk("sd_stall_after", stall_o, 1'b0);

    // SB at 0x1003
    mem_write_i = 1'b1;
    write_type_i = 2'd0;
    addr_i = 64'h1003;
    wdata_i = 64'hAB;
    dmem_gnt_i = 1'b1;
    step();
    chk("sb_wstrb", dmem_wstrb_o, 8'h08);
    chk("sb_wdata", dmem_wdata_o, 64'h00000000AB000000);
    chk("sb_addr", dmem_addr_o, 64'h1000);
    step();
    chk("sb_stall_done", stall_o, 1'b0);
    mem_write_i = 1'b0;
    dmem_gnt_i = 1'b0;
    step();

    // loads of each type
    run_load("lb",  3'd0, 64'h2005, 64'h0000800000000000, 64'hFFFFFFFFFFFFFF80);
    run_load("lbu", 3'd4, 64'h2005, 64'h0000800000000000, 64'h0000000000000080);
    run_load("lh",  3'd1, 64'h2006, 64'h8001000000000000, 64'hFFFFFFFFFFFF8001);
    run_load("lhu", 3'd5, 64'h2006, 64'h8001000000000000, 64'h0000000000008001);
    run_load("lwu", 3'd6, 64'h3004, 64'h89ABCDEF00000000, 64'h0000000089ABCDEF);
    run_load("ld7", 3'd7, 64'h5000, 64'hFEDCBA9876543210, 64'hFEDCBA9876543210);

    // SW at 0x4004 with gnt delayed three cycles
    mem_write_i = 1'b1;
    write_type_i = 2'd2;
    addr_i = 64'h4004;
    wdata_i = 64'hDEADBEEF;
    dmem_gnt_i = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("swd_req", dmem_req_o, 1'b1);
      chk("swd_addr", dmem_addr_o, 64'h4000);
      chk("swd_wstrb", dmem_wstrb_o, 8'hF0);
      chk("swd_wdata", dmem_wdata_o, 64'hDEADBEEF00000000);
      chk("swd_stall", stall_o, 1'b1);
      step();
    end
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("swd_stall_done", stall_o, 1'b0);
    chk("swd_req_done", dmem_req_o, 1'b0);
    mem_write_i = 1'b0;
    step();

    // LW at 0x3004 with gnt delayed and stray rvalid before gnt
    mem_read_i = 1'b1;
    read_type_i = 3'd2;
    addr_i = 64'h3004;
    step();
    for (int i = 0; i < 3; i++) begin
      dmem_rvalid_i = 1'b1;
      dmem_rdata_i = 64'h7777777777777777;
      #1;
      chk("lwd_req", dmem_req_o, 1'b1);
      chk("lwd_addr", dmem_addr_o, 64'h3000);
      chk("lwd_stall", stall_o, 1'b1);
      chk("lwd_rvalid_early", rdata_valid_o, 1'b0);
      step();
    end
    dmem_rvalid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 64'h8000000100000000;
    #1;
    chk("lwd_req_wait", dmem_req_o, 1'b0);
    chk("lwd_rvalid_wait", rdata_valid_o, 1'b0);
    step();
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i = 64'h0;
    chk("lwd_rdata", rdata_o, 64'hFFFFFFFF80000001);
    chk("lwd_rvalid_done", rdata_valid_o, 1'b1);
    mem_read_i = 1'b0;
    step();

    // misaligned LW at 0x3002
    mem_read_i = 1'b1;
    read_type_i = 3'd2;
    addr_i = 64'h3002;
    #1;
    chk("mis_flag", misalign_o, 1'b1);
    chk("mis_stall", stall_o, 1'b0);
    step();
    chk("mis_req", dmem_req_o, 1'b0);
    chk("mis_flag_hold", misalign_o, 1'b1);
    mem_read_i = 1'b0;
    mem_write_i = 1'b1;
    write_type_i = 2'd1;
    addr_i = 64'h3001;
    #1;
    chk("mis_sh", misalign_o, 1'b1);
    step();
    chk("mis_sh_req", dmem_req_o, 1'b0);
    mem_write_i = 1'b0;
    #1;
    chk("mis_clear", misalign_o, 1'b0);
    step();

    // reset while waiting for read data, then a stray rvalid
    mem_read_i = 1'b1;
    read_type_i = 3'd0;
    addr_i = 64'h2005;
    step();
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    chk("rstw_stall_wait", stall_o, 1'b1);
    rst = 1'b1;
    mem_read_i = 1'b0;
    step();
    rst = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 64'h0000800000000000;
    #1;
    chk("rstw_req", dmem_req_o, 1'b0);
    chk("rstw_addr", dmem_addr_o, 64'h0);
    chk("rstw_rdata", rdata_o, 64'h0);
    chk("rstw_rvalid", rdata_valid_o, 1'b0);
    chk("rstw_stall", stall_o, 1'b0);
    step();
    dmem_rvalid_i = 1'b0;
    chk("rstw_rvalid_after", rdata_valid_o, 1'b0);
    chk("rstw_rdata_after", rdata_o, 64'h0);
    chk("rstw_req_after", dmem_req_o, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_lsu_ctrl.md
Name: core_lsu_ctrl

Overview:
- MEM-stage load/store sequencer. Sits between the EX/MEM pipeline register outputs and the data-memory port.
- Converts the registered mem_read/mem_write controls into a req/gnt/rvalid transaction, aligns store data and byte strobes, and extracts and extends load data.
- Raises stall_o so the hazard unit holds EX/MEM and all earlier stages until the access completes.

Parameters:
- XLEN, 64, operand/address width.
- STRB_W, XLEN/8, byte-strobe width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_read_i  in  1  load in MEM stage.
- mem_write_i  in  1  store in MEM stage.
- read_type_i  in  3  load size/sign: LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6.
- write_type_i  in  2  store size: SB=0, SH=1, SW=2, SD=3.
- addr_i  in  XLEN  effective address (ALU result).
- wdata_i  in  XLEN  store data (rs2 value).
- dmem_req_o  out  1  request valid.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  XLEN  doubleword-aligned address ({addr[63:3],3'b0}).
- dmem_wstrb_o  out  STRB_W  byte enables.
- dmem_wdata_o  out  XLEN  lane-shifted store data.
- dmem_gnt_i  in  1  request accepted.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  raw doubleword.
- rdata_o  out  XLEN  aligned, extended load result.
- rdata_valid_o  out  1  rdata_o valid this cycle.
- stall_o  out  1  hold EX/MEM and earlier registers.
- misalign_o  out  1  current access is misaligned.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o, rdata_o, rdata_valid_o all 0.
- op = mem_read_i | mem_write_i. If both are set, the read is performed and the write is ignored.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0; D requires addr[2:0]=0. read_type 7 is treated as LD.
- misalign_o = op & misaligned (combinational). A misaligned op issues no request, asserts no stall, and leaves state at IDLE; the trap is raised elsewhere.
- stall_o = op & ~misaligned & (state != DONE) (combinational). It is high from the first cycle the op is presented.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on a legal op, register the request fields and go to REQ.
  - REQ: dmem_req_o=1. Request fields stay stable until dmem_gnt_i. On gnt, a write goes to DONE and a read goes to WAIT.
  - WAIT: dmem_req_o=0. On dmem_rvalid_i, capture the extended data into rdata_o and go to DONE. gnt is ignored in WAIT.
  - DONE: stall_o=0, rdata_valid_o=1 (reads only), always go to IDLE. The pipeline advances at this edge.
- Latency with gnt in REQ's first cycle:
  - Store: 3 cycles (IDLE, REQ, DONE).
  - Load with rvalid one cycle after gnt: 4 cycles.
- Back-to-back ops: the next op appears in IDLE the cycle after DONE, with no bubble beyond that.
- Store lane: wdata_o = wdata_i << (8*addr[2:0]).
- Store strobes: SB=8'h01, SH=8'h03, SW=8'h0F, SD=8'hFF, each shifted left by addr[2:0].
- Load extraction: take the byte(s) at offset addr[2:0] of dmem_rdata_i. Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU/LD.
- rdata_o holds its value until the next load capture.
- dmem_rvalid_i in IDLE, REQ or DONE is ignored. The memory guarantees rvalid arrives at least one cycle after gnt.
- Reset mid-transaction (REQ or WAIT): drop the request next cycle and return to IDLE; any later stray rvalid is ignored.
- Unsigned address arithmetic only; no wrap checks.

Decomposition:
- Shared package (core defines):
  - read_type encodings: RT_LB..RT_LWU.
  - write_type encodings: WT_SB..WT_SD.
  - LSU state encoding: LSU_IDLE=0, LSU_REQ=1, LSU_WAIT=2, LSU_DONE=3.
- One sub-module, core_lsu_align: purely combinational. Computes the misalign flag, store strobes and shifted wdata, and load extraction/extension. core_lsu_ctrl holds the FSM and registers only.

Test Plan:
- SD addr=0x1000, wdata=0x1122334455667788, gnt on first REQ cycle -> req for 1 cycle, wstrb=0xFF, wdata unchanged, stall high for 2 cycles then low in DONE.
- SB addr=0x1003, wdata=0xAB -> wstrb=0x08, wdata_o=0x00000000AB000000, dmem_addr_o=0x1000.
- LB addr=0x2005, rdata=0x0000800000000000 (byte5=0x80), rvalid 2 cycles after gnt -> rdata_o=0xFFFFFFFFFFFFFF80, rdata_valid_o for exactly 1 cycle. Repeat with LBU -> 0x80.
- gnt delayed 3 cycles -> req, addr, wstrb stable throughout; stall held; no rvalid accepted before gnt.
- LW addr=0x3002 -> misalign_o=1, stall_o=0, no dmem_req_o, state stays IDLE.
- rst asserted in WAIT, then rvalid pulsed -> all outputs 0 and IDLE next cycle, rvalid ignored, rdata_valid_o stays 0.
